prim_pad_in_filter: RTL and testbench
=====================================

// Module: prim_pad_in_filter
// PURPOSE
//  Conditions the raw input path of a bidirectional pad. It consumes in_o of the pad wrapper,
//  which is asynchronous to clk_i. It provides a 2-flop synchronizer, an optional programmable
//  debounce/glitch filter, registered rise/fall event pulses, and a saturating count of
//  rejected glitches. It sits between the pad wrapper and pinmux/peripheral inputs.
// PARAMETERS
//  CntWidth    4     width of debounce counter and thresh_i
//  GlitchCntW  8     width of rejected-glitch counter
//  ResetValue  1'b0  reset value of synchronizer flops and filtered_o
// PORTS
//  clk_i          in   1           clock
//  rst_ni         in   1           reset, asynchronous, active-low
//  pad_in_i       in   1           raw pad input (pad wrapper in_o), async to clk_i
//  filter_en_i    in   1           1: debounce filter active; 0: bypass (sync only)
//  thresh_i       in   CntWidth    debounce threshold T (quasi-static)
//  clr_glitch_i   in   1           synchronous clear of glitch_cnt_o
//  filtered_o     out  1           synchronized, filtered pad value
//  rise_o         out  1           1-cycle pulse: filtered_o went 0->1
//  fall_o         out  1           1-cycle pulse: filtered_o went 1->0
//  stable_o       out  1           synchronized input equals filtered_o and no count pending
//  glitch_cnt_o   out  GlitchCntW  saturating count of rejected glitches
// BEHAVIOUR
//  Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
//  Reset values: sync flops = ResetValue, filtered_o = ResetValue, cnt = 0, rise_o = fall_o = 0,
//   stable_o = 1, glitch_cnt_o = 0. No edge pulse on reset release.
//  Sync: ff1 <= pad_in_i; s <= ff1. No logic between ff1 and s.
//  Filter, evaluated each cycle (d = s != filtered_o):
//   - filter_en_i=0 or T=0: filtered_o <= s; cnt <= 0.
//   - d=1 and cnt >= T: filtered_o <= s; cnt <= 0.
//   - d=1 and cnt < T: cnt <= cnt+1.
//   - d=0: cnt <= 0. If cnt != 0, this is a rejected glitch.
//  Using cnt >= T means lowering T mid-count takes effect at once and cannot deadlock.
//  Latency: a pad level captured by ff1 at edge N reaches filtered_o after edge N+2+T.
//   In bypass, it reaches filtered_o after edge N+2. Pulses held <= T cycles at s are suppressed.
//  filter_en_i 1->0 mid-count: cnt cleared; bypass from the same edge. 0->1 starts with cnt = 0.
//  rise_o/fall_o: registered, set on the same edge filtered_o changes and high for exactly one
//   cycle. They are mutually exclusive. Back-to-back changes give back-to-back pulses.
//  stable_o: registered; stable_o <= (next cnt == 0) && (s == next filtered_o).
//  glitch_cnt_o: increments on each rejected glitch and saturates at all-ones.
//   clr_glitch_i has priority: clear to 0 and drop a coincident increment.
//  Bypass mode never counts glitches.
// TESTING
//  1. Reset: rst_ni low mid-cycle -> all outputs take reset values immediately (async).
//     ResetValue=1 gives filtered_o=1 with no fall_o at release.
//  2. Bypass: en=0, pad 0->1 captured at edge N -> filtered_o=1 and rise_o=1 after edge N+2.
//     rise_o=0 after N+3.
//  3. Debounce: en=1, T=3, clean step 0->1 -> filtered_o rises after edge N+5 with a single rise_o.
//     stable_o is low during edges N+2..N+4.
//  4. Glitch: en=1, T=3, pad high for 3 cycles then low -> filtered_o stays 0, no rise_o,
//     glitch_cnt_o=1. 300 glitches -> glitch_cnt_o=255 (saturated).
//  5. clr_glitch_i on the same cycle as a glitch rejection -> glitch_cnt_o=0.
//     Lower T from 7 to 2 while cnt=5 -> filtered_o updates on the next edge.
//  6. Random async pad toggling vs reference model: filtered_o and pulses match and rise_o/fall_o
//     are never high together; en toggled mid-count clears cnt.

Source files
------------

// File: rtl/prim_pad_in_filter.sv
// Input conditioning for a bidirectional pad: 2-flop synchronizer, optional debounce filter,
// registered edge pulses, a stability flag and a saturating count of rejected glitches.
module prim_pad_in_filter #(
  parameter int unsigned CntWidth   = 4,
  parameter int unsigned GlitchCntW = 8,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pad_in_i,
  input  logic                  filter_en_i,
  input  logic [CntWidth-1:0]   thresh_i,
  input  logic                  clr_glitch_i,
  output logic                  filtered_o,
  output logic                  rise_o,
  output logic                  fall_o,
  output logic                  stable_o,
  output logic [GlitchCntW-1:0] glitch_cnt_o
);

  localparam int unsigned SyncStages = 2;

  // Plain flop chain: nothing may sit between the stages or metastability hardening is lost.
  logic [SyncStages:0] sync_chain;
  assign sync_chain[0] = pad_in_i;

  for (genvar gi = 0; gi < SyncStages; gi++) begin : g_sync
    logic stage_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= ResetValue;
      end else begin
        stage_q <= sync_chain[gi];
      end
    end
    assign sync_chain[gi+1] = stage_q;
  end

  logic                  sync_s;
  logic                  filt_q, filt_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  stable_q, stable_d;
  logic [GlitchCntW-1:0] glitch_cnt_q, glitch_cnt_d;
  logic                  bypass;
  logic                  glitch;

  assign sync_s = sync_chain[SyncStages];
  assign bypass = !filter_en_i || (thresh_i == '0);

  always_comb begin
    filt_d       = filt_q;
    cnt_d        = '0;
    glitch       = 1'b0;
    glitch_cnt_d = glitch_cnt_q;

    if (bypass) begin
      filt_d = sync_s;
    end else if (sync_s != filt_q) begin
      // Comparing with >= lets a lowered threshold take effect on the very next edge.
      if (cnt_q >= thresh_i) begin
        filt_d = sync_s;
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end else begin
      glitch = (cnt_q != '0);
    end

    if (clr_glitch_i) begin
      glitch_cnt_d = '0;
    end else if (glitch && (glitch_cnt_q != {GlitchCntW{1'b1}})) begin
      glitch_cnt_d = glitch_cnt_q + GlitchCntW'(1);
    end

    rise_d   = filt_d && !filt_q;
    fall_d   = !filt_d && filt_q;
    stable_d = (cnt_d == '0) && (sync_s == filt_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q       <= ResetValue;
      cnt_q        <= '0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      stable_q     <= 1'b1;
      glitch_cnt_q <= '0;
    end else begin
      filt_q       <= filt_d;
      cnt_q        <= cnt_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      stable_q     <= stable_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign filtered_o   = filt_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign stable_o     = stable_q;
  assign glitch_cnt_o = glitch_cnt_q;

endmodule

// File: tb/tb_prim_pad_in_filter.sv
// Bench for prim_pad_in_filter: two instances (ResetValue 0 and 1) share stimulus; a monitor
// compares every post-edge output against a queue filled by a behavioural model.
module tb_prim_pad_in_filter;

  localparam int CW   = 4;
  localparam int GW   = 8;
  localparam int GMAX = (1 << GW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          pad   = 1'b0;
  logic          en    = 1'b0;
  logic          clr   = 1'b0;
  logic [CW-1:0] thr   = '0;

  logic          filt [2];
  logic          rise [2];
  logic          fall [2];
  logic          stab [2];
  logic [GW-1:0] gc   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prim_pad_in_filter #(.CntWidth(CW), .GlitchCntW(GW), .ResetValue(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .pad_in_i(pad), .filter_en_i(en), .thresh_i(thr),
    .clr_glitch_i(clr), .filtered_o(filt[0]), .rise_o(rise[0]), .fall_o(fall[0]),
    .stable_o(stab[0]), .glitch_cnt_o(gc[0])
  );

  prim_pad_in_filter #(.CntWidth(CW), .GlitchCntW(GW), .ResetValue(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .pad_in_i(pad), .filter_en_i(en), .thresh_i(thr),
    .clr_glitch_i(clr), .filtered_o(filt[1]), .rise_o(rise[1]), .fall_o(fall[1]),
    .stable_o(stab[1]), .glitch_cnt_o(gc[1])
  );

  typedef struct packed {
    logic          filt;
    logic          rise;
    logic          fall;
    logic          stab;
    logic [GW-1:0] gc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state: pad history through the two sync stages, the filtered level,
  // the length of the current run of edges where the synced input disagreed, glitch tally.
  logic m_ff1    [2];
  logic m_s      [2];
  logic m_filt   [2];
  int   m_streak [2];
  int   m_gc     [2];

  function automatic logic rv(input int i);
    return (i == 1);
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t got %0h expected %0h", name, inst, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ff1[i]    = rv(i);
      m_s[i]      = rv(i);
      m_filt[i]   = rv(i);
      m_streak[i] = 0;
      m_gc[i]     = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Predicts the outputs right after the coming clock edge, given the inputs now applied.
  task automatic model_edge(input int i, output exp_t e);
    logic s_now, old, glitch;
    int   t;
    s_now  = m_s[i];
    old    = m_filt[i];
    glitch = 1'b0;
    t      = int'(thr);
    if (!en || t == 0) begin
      m_filt[i]   = s_now;
      m_streak[i] = 0;
    end else if (s_now != m_filt[i]) begin
      m_streak[i] = m_streak[i] + 1;
      if (m_streak[i] > t) begin
        m_filt[i]   = s_now;
        m_streak[i] = 0;
      end
    end else begin
      glitch      = (m_streak[i] > 0);
      m_streak[i] = 0;
    end
    if (clr) m_gc[i] = 0;
    else if (glitch && m_gc[i] < GMAX) m_gc[i] = m_gc[i] + 1;
    e.filt = m_filt[i];
    e.rise = !old && m_filt[i];
    e.fall = old && !m_filt[i];
    e.stab = (m_streak[i] == 0) && (s_now == m_filt[i]);
    e.gc   = GW'(m_gc[i]);
    m_s[i]   = m_ff1[i];
    m_ff1[i] = pad;
  endtask

  task automatic predict();
    exp_t x0, x1;
    model_edge(0, x0);
    model_edge(1, x1);
    q0.push_back(x0);
    q1.push_back(x1);
  endtask

  task automatic cyc(input logic p, input logic e, input int t, input logic c);
    @(negedge clk);
    pad = p;
    en  = e;
    thr = CW'(t);
    clr = c;
    if (rst_n) predict();
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_filt", i, filt[i], rv(i));
      chk("rst_rise", i, rise[i], 0);
      chk("rst_fall", i, fall[i], 0);
      chk("rst_stable", i, stab[i], 1);
      chk("rst_gcnt", i, gc[i], 0);
    end
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    predict();
  endtask

  task automatic cmp_inst(input int i, input exp_t e);
    chk("filtered", i, filt[i], e.filt);
    chk("rise", i, rise[i], e.rise);
    chk("fall", i, fall[i], e.fall);
    chk("stable", i, stab[i], e.stab);
    chk("glitch_cnt", i, gc[i], e.gc);
    chk("rise_fall_excl", i, rise[i] & fall[i], 0);
  endtask

  // Monitor: every active edge out of reset must match the next queued prediction.
  initial begin
    exp_t e0, e1;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty t=%0t got 0 entries required 1", $time);
        end else begin
          e0 = q0.pop_front();
          e1 = q1.pop_front();
          cmp_inst(0, e0);
          cmp_inst(1, e1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got timeout required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw_rise;
    logic p;
    logic e;
    int   t;
    int   hold;

    #1;
    assert_reset();
    $display("txn reset asserted before first edge");
    repeat (3) @(posedge clk);
    release_reset();
    peek();
    chk("rv1_no_fall_at_release", 1, fall[1], 0);
    chk("rv1_filt_at_release", 1, filt[1], 1);
    chk("rv0_no_rise_at_release", 0, rise[0], 0);
    $display("txn reset released");

    repeat (4) cyc(1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, 0, 1'b0);
      peek();
      if (k == 1) chk("bypass_early", 0, filt[0], 0);
      if (k == 2) begin
        chk("bypass_filt_N2", 0, filt[0], 1);
        chk("bypass_rise_N2", 0, rise[0], 1);
      end
      if (k == 3) chk("bypass_rise_N3", 0, rise[0], 0);
    end
    $display("txn bypass step 0->1");

    repeat (6) cyc(1'b0, 1'b1, 3, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 3, 1'b0);
      peek();
      if (k >= 2 && k <= 4) begin
        chk("deb_stable_low", 0, stab[0], 0);
        chk("deb_filt_hold", 0, filt[0], 0);
      end
      if (k == 5) begin
        chk("deb_filt_N5", 0, filt[0], 1);
        chk("deb_rise_N5", 0, rise[0], 1);
        chk("deb_stable_N5", 0, stab[0], 1);
      end
      if (k == 6) chk("deb_rise_single", 0, rise[0], 0);
    end
    $display("txn debounce T=3 step 0->1");

    cyc(1'b0, 1'b1, 3, 1'b1);
    repeat (8) cyc(1'b0, 1'b1, 3, 1'b0);
    saw_rise = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cyc((k < 3), 1'b1, 3, 1'b0);
      peek();
      saw_rise |= rise[0];
    end
    chk("glitch_no_rise", 0, saw_rise, 0);
    chk("glitch_filt", 0, filt[0], 0);
    chk("glitch_cnt_1", 0, gc[0], 1);
    $display("txn glitch T=3 3-cycle pulse");

    for (int g = 0; g < 300; g++) begin
      for (int k = 0; k < 5; k++) cyc((k < 2), 1'b1, 3, 1'b0);
    end
    peek();
    chk("glitch_saturate", 0, gc[0], GMAX);
    $display("txn 300 glitches");

    for (int k = 0; k < 7; k++) begin
      cyc((k < 3), 1'b1, 3, (k == 5));
      peek();
      if (k == 4) chk("pre_clr_sat", 0, gc[0], GMAX);
      if (k == 5) chk("clr_beats_incr", 0, gc[0], 0);
    end
    $display("txn clear coincident with glitch");

    repeat (10) cyc(1'b0, 1'b1, 7, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 1'b1, 7, 1'b0);
      peek();
    end
    chk("t7_pending", 0, filt[0], 0);
    cyc(1'b1, 1'b1, 2, 1'b0);
    peek();
    chk("lower_t_filt", 0, filt[0], 1);
    chk("lower_t_rise", 0, rise[0], 1);
    $display("txn threshold lowered 7->2 at cnt=5");

    p    = 1'b0;
    hold = 0;
    for (int b = 0; b < 120; b++) begin
      e = ($urandom_range(0, 4) != 0);
      t = $urandom_range(0, 15);
      if (b == 60) begin
        @(posedge clk);
        #3;
        assert_reset();
        repeat (2) @(posedge clk);
        release_reset();
      end
      for (int k = 0; k < 30; k++) begin
        if (hold == 0) begin
          p    = $urandom_range(0, 1);
          hold = $urandom_range(1, 8);
        end
        hold--;
        if ($urandom_range(0, 9) == 0) e = !e;
        if ($urandom_range(0, 14) == 0) t = $urandom_range(0, 15);
        cyc(p, e, t, ($urandom_range(0, 19) == 0));
      end
      $display("txn random burst %0d en=%0d T=%0d", b, e, t);
    end

    repeat (3) cyc(p, 1'b0, 0, 1'b0);
    peek();
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
